// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle 16-bit-instruction CPU core.
// Each instruction steps through five one-hot phases (IF, ID, AL, EX, WB) on a
// single clock. iRUN stalls all state, HLT parks the core until reset, and a
// combinational debug port reads back the register file.
module cpu_core_mc #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRUN,
  output logic [PC_W-1:0]   oIMEM_ADDR,
  input  logic [15:0]       iIMEM_DATA,
  input  logic [1:0]        iDBG_IDX,
  output logic [DATA_W-1:0] oDBG_VAL,
  output logic [4:0]        oPHASE,
  output logic [PC_W-1:0]   oPC,
  output logic              oZ,
  output logic              oC,
  output logic              oRETIRE,
  output logic              oHALTED
);

  typedef enum logic [4:0] {
    PH_IF = 5'b00001,
    PH_ID = 5'b00010,
    PH_AL = 5'b00100,
    PH_EX = 5'b01000,
    PH_WB = 5'b10000
  } phase_t;

  phase_t            phase_reg, phase_next;
  logic              retire_next;
  logic [15:0]       ir_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [DATA_W-1:0] regs_reg [NREG];
  logic [DATA_W-1:0] a_reg, b_reg, res_reg;
  logic              z_reg, c_reg, nz_reg, nc_reg;
  logic              wr_reg, taken_reg, halted_reg;

  // Instruction fields, decoded straight from IR.
  logic [3:0] op;
  logic [1:0] dst, src1, src2;
  logic [7:0] imm;
  assign op   = ir_reg[15:12];
  assign dst  = ir_reg[11:10];
  assign src1 = ir_reg[9:8];
  assign src2 = ir_reg[1:0];
  assign imm  = ir_reg[7:0];

  // A halted core ignores iRUN entirely; only reset brings it back.
  logic advance;
  assign advance = iRUN && !halted_reg;

  // Per-register write strobes for the WB commit.
  logic [NREG-1:0] wr_sel;
  for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
    assign wr_sel[gi] = wr_reg && (dst == 2'(gi));
  end

  // Phase state register.
  always_ff @(posedge iCLK) begin
    if (iRST) phase_reg <= PH_IF;
    else      phase_reg <= phase_next;
  end

  // Next phase; the retire strobe is asserted during a WB cycle that advances.
  always_comb begin
    phase_next  = phase_reg;
    retire_next = 1'b0;
    if (advance) begin
      case (phase_reg)
        PH_IF: phase_next = PH_ID;
        PH_ID: phase_next = PH_AL;
        PH_AL: phase_next = PH_EX;
        PH_EX: phase_next = PH_WB;
        PH_WB: begin
          phase_next  = PH_IF;
          retire_next = 1'b1;
        end
        default: phase_next = PH_IF;
      endcase
    end
  end

  // ALU over the operands latched at AL. Carry is a borrow for subtraction.
  logic [DATA_W:0]   sum_w, diff_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_wr, br_taken;
  assign sum_w  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_w = {1'b0, a_reg} - {1'b0, b_reg};

  // Result, carry, write-enable and branch decision for the EX phase.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_wr   = 1'b1;
    br_taken = 1'b0;
    case (op)
      4'h1, 4'h7: {alu_c, alu_res} = sum_w;
      4'h2, 4'h8: {alu_c, alu_res} = diff_w;
      4'h3:       alu_res = a_reg & b_reg;
      4'h4:       alu_res = a_reg | b_reg;
      4'h5:       alu_res = a_reg ^ b_reg;
      4'h6, 4'h9: alu_res = b_reg;
      4'hA:       {alu_c, alu_res} = {a_reg, 1'b0};
      4'hB:       {alu_res, alu_c} = {1'b0, a_reg};
      default: begin
        alu_wr   = 1'b0;
        br_taken = (op == 4'hC) || (op == 4'hD && z_reg) || (op == 4'hE && !z_reg);
      end
    endcase
  end

  // Datapath: fetch, operand latch, execute latch and write-back commit.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ir_reg     <= '0;
      pc_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      nz_reg     <= 1'b0;
      nc_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      taken_reg  <= 1'b0;
      halted_reg <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (advance) begin
      case (phase_reg)
        PH_IF: ir_reg <= iIMEM_DATA;
        PH_AL: begin
          a_reg <= regs_reg[src1];
          b_reg <= (op == 4'h7 || op == 4'h8 || op == 4'h9) ? DATA_W'(imm) : regs_reg[src2];
        end
        PH_EX: begin
          res_reg   <= alu_res;
          nz_reg    <= (alu_res == '0);
          nc_reg    <= alu_c;
          wr_reg    <= alu_wr;
          taken_reg <= br_taken;
        end
        PH_WB: begin
          for (int i = 0; i < NREG; i++) begin
            if (wr_sel[i]) regs_reg[i] <= res_reg;
          end
          if (wr_reg) begin
            z_reg <= nz_reg;
            c_reg <= nc_reg;
          end
          if (op == 4'hF)     halted_reg <= 1'b1;
          else if (taken_reg) pc_reg     <= imm[PC_W-1:0];
          else                pc_reg     <= pc_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oIMEM_ADDR = pc_reg;
  assign oPC        = pc_reg;
  assign oPHASE     = phase_reg;
  assign oZ         = z_reg;
  assign oC         = c_reg;
  assign oHALTED    = halted_reg;
  assign oRETIRE    = retire_next && !iRST;
  assign oDBG_VAL   = regs_reg[iDBG_IDX];

endmodule

// File: tb/tb_cpu_core_mc.sv
// Testbench for cpu_core_mc: an instruction-level interpreter predicts the
// architectural state after every retired instruction; a monitor pops those
// predictions whenever the core retires and compares them.
module tb_cpu_core_mc;

  logic        iCLK = 1'b0;
  logic        iRST, iRUN;
  logic [7:0]  oIMEM_ADDR;
  logic [15:0] iIMEM_DATA;
  logic [1:0]  iDBG_IDX;
  logic [7:0]  oDBG_VAL;
  logic [4:0]  oPHASE;
  logic [7:0]  oPC;
  logic        oZ, oC, oRETIRE, oHALTED;

  cpu_core_mc #(.DATA_W(8), .PC_W(8), .NREG(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN),
    .oIMEM_ADDR(oIMEM_ADDR), .iIMEM_DATA(iIMEM_DATA),
    .iDBG_IDX(iDBG_IDX), .oDBG_VAL(oDBG_VAL),
    .oPHASE(oPHASE), .oPC(oPC), .oZ(oZ), .oC(oC),
    .oRETIRE(oRETIRE), .oHALTED(oHALTED)
  );

  always #5 iCLK = ~iCLK;

  logic [15:0] imem [256];
  assign iIMEM_DATA = imem[oIMEM_ADDR];

  typedef struct {
    int pc;
    int z;
    int c;
    int halted;
    int idx;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mr[4];
  int   mz, mc, mpc, mhalt;

  logic       pend = 1'b0;
  logic [1:0] mon_idx = 2'd0;
  logic [1:0] drv_idx = 2'd0;
  bit         cad_en = 1'b0;
  int         last_ret = -1;
  exp_t       cur;

  assign iDBG_IDX = pend ? mon_idx : drv_idx;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(posedge iCLK) cyc++;

  // Monitor: on retire, pop a prediction; compare it one cycle later, once committed.
  always @(negedge iCLK) begin
    if (pend) begin
      check("pc", int'(oPC), cur.pc);
      check("z", int'(oZ), cur.z);
      check("c", int'(oC), cur.c);
      check("halted", int'(oHALTED), cur.halted);
      check("reg", int'(oDBG_VAL), cur.val);
      $display("retire pc=%0d z=%0d c=%0d R%0d=%0d", oPC, oZ, oC, mon_idx, oDBG_VAL);
      pend = 1'b0;
    end
    if (iRST) last_ret = -1;
    if (!iRUN) check("stall_retire", int'(oRETIRE), 0);
    if (oRETIRE) begin
      if (cad_en && last_ret >= 0) check("retire_gap", cyc - last_ret, 5);
      last_ret = cyc;
      if (exp_q.size() == 0) check("unexpected_retire", 1, 0);
      else begin
        cur     = exp_q.pop_front();
        mon_idx = 2'(cur.idx);
        pend    = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    iRUN = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
  endtask

  // Instruction-set interpreter: plain integer arithmetic mod 256.
  task automatic model_run(input int n);
    exp_t e;
    logic [15:0] w;
    int op, d, s1, s2, imm, a, b, res, wr, npc;
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mz = 0; mc = 0; mpc = 0; mhalt = 0;
    for (int i = 0; i < n && mhalt == 0; i++) begin
      w   = imem[mpc];
      op  = int'(w[15:12]);
      d   = int'(w[11:10]);
      s1  = int'(w[9:8]);
      s2  = int'(w[1:0]);
      imm = int'(w[7:0]);
      a   = mr[s1];
      b   = mr[s2];
      wr  = 1;
      res = 0;
      npc = (mpc + 1) % 256;
      case (op)
        1:  begin res = (a + b) % 256;         mc = (a + b > 255) ? 1 : 0; end
        2:  begin res = (a - b + 256) % 256;   mc = (a < b) ? 1 : 0; end
        3:  begin res = a & b;                 mc = 0; end
        4:  begin res = a | b;                 mc = 0; end
        5:  begin res = a ^ b;                 mc = 0; end
        6:  begin res = b;                     mc = 0; end
        7:  begin res = (a + imm) % 256;       mc = (a + imm > 255) ? 1 : 0; end
        8:  begin res = (a - imm + 256) % 256; mc = (a < imm) ? 1 : 0; end
        9:  begin res = imm;                   mc = 0; end
        10: begin res = (a * 2) % 256;         mc = (a >= 128) ? 1 : 0; end
        11: begin res = a / 2;                 mc = a % 2; end
        12: begin wr = 0; npc = imm; end
        13: begin wr = 0; if (mz == 1) npc = imm; end
        14: begin wr = 0; if (mz == 0) npc = imm; end
        15: begin wr = 0; npc = mpc; mhalt = 1; end
        default: wr = 0;
      endcase
      if (wr == 1) begin
        mr[d] = res;
        mz    = (res == 0) ? 1 : 0;
      end
      mpc      = npc;
      e.pc     = mpc;
      e.z      = mz;
      e.c      = mc;
      e.halted = mhalt;
      e.idx    = (wr == 1) ? d : int'($urandom_range(3, 0));
      e.val    = mr[e.idx];
      exp_q.push_back(e);
    end
  endtask

  // Reset the core and let it run until every prediction has been checked.
  task automatic run_prog(input bit rnd_run, input bit stall_ex, input int budget);
    bit stalled_done = 1'b0;
    int k = 0;
    int ph, p;
    cad_en = !rnd_run && !stall_ex;
    do_reset();
    while ((exp_q.size() != 0 || pend) && k < budget) begin
      if (stall_ex && !stalled_done && oPHASE == 5'b01000) begin
        ph = int'(oPHASE);
        p  = int'(oPC);
        iRUN = 1'b0;
        repeat (7) tick();
        check("stall_phase", int'(oPHASE), ph);
        check("stall_pc", int'(oPC), p);
        stalled_done = 1'b1;
      end
      iRUN = rnd_run ? ($urandom_range(3, 0) != 0) : 1'b1;
      tick();
      k++;
    end
    check("queue_drained", exp_q.size(), 0);
    iRUN = 1'b0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      drv_idx = 2'(i);
      #1;
      check("final_reg", int'(oDBG_VAL), mr[i]);
    end
    check("final_z", int'(oZ), mz);
    check("final_c", int'(oC), mc);
    check("final_pc", int'(oPC), mpc);
    check("final_halted", int'(oHALTED), mhalt);
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  initial begin
    logic [15:0] w;
    iRST = 1'b1;
    iRUN = 1'b0;
    load_clear();

    // Reset state.
    model_run(0);
    do_reset();
    iRUN = 1'b0;
    check("reset_phase", int'(oPHASE), 1);
    check("reset_retire", int'(oRETIRE), 0);
    check_regs();

    // MOVI/MOVI/ADD with carry-out to zero, at full speed.
    load_clear();
    imem[0] = 16'h9405; imem[1] = 16'h98FB; imem[2] = 16'h1D02; imem[3] = 16'hF000;
    model_run(10);
    run_prog(1'b0, 1'b0, 200);
    check_regs();

    // Borrow from zero, then shift right.
    load_clear();
    imem[0] = 16'h8001; imem[1] = 16'hB000; imem[2] = 16'hF000;
    model_run(10);
    run_prog(1'b0, 1'b0, 200);
    check_regs();

    // Countdown loop ending in HLT; the halted core must ignore iRUN.
    load_clear();
    imem[0] = 16'h9003; imem[1] = 16'h8001; imem[2] = 16'hE001; imem[3] = 16'hF000;
    model_run(20);
    run_prog(1'b0, 1'b0, 400);
    check_regs();
    for (int i = 0; i < 10; i++) begin
      iRUN = $urandom_range(1, 0) != 0;
      tick();
    end
    check("halt_pc", int'(oPC), 3);
    check("halt_phase", int'(oPHASE), 1);
    check("halt_flag", int'(oHALTED), 1);

    // Seven-cycle stall in EX must not change the results.
    load_clear();
    imem[0] = 16'h9405; imem[1] = 16'h98FB; imem[2] = 16'h1D02; imem[3] = 16'hF000;
    model_run(10);
    run_prog(1'b0, 1'b1, 300);
    check_regs();

    // PC wrap through a jump to the last address.
    load_clear();
    imem[0] = 16'hC0FF; imem[255] = 16'h0000;
    model_run(3);
    run_prog(1'b0, 1'b0, 200);
    check_regs();

    // Randomized programs with random stalls.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(7, 0) != 0) w[15:12] = 4'h9;
        imem[i] = w;
      end
      model_run(30);
      run_prog(1'b1, 1'b0, 2000);
      check_regs();
    end

    // Reset asserted during AL discards the in-flight MOVI.
    load_clear();
    imem[0] = 16'h9477;
    model_run(0);
    do_reset();
    for (int k = 0; k < 10 && oPHASE != 5'b00100; k++) tick();
    check("reached_al", int'(oPHASE), 4);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    iRUN = 1'b0;
    check("al_reset_phase", int'(oPHASE), 1);
    check_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
